// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel parity receiver.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int                ERR_W   = 8;
  localparam logic [ERR_W-1:0]  ERR_SAT = 8'hFF;

endpackage

// File: rtl/s2p_parity_rx.sv
// LSB-first serial receiver with trailing parity: word + valid one cycle after the parity bit, abort one cycle after start rises mid-frame.
// No backpressure: start (active low) paces the link and one bit is taken every clock while it is low.
module s2p_parity_rx
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             incoming,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             abort,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_acc;
  logic             perr;

  // Running XOR of the data bits, so the parity check is one gate on the last cycle.
  assign perr = incoming ^ par_acc ^ ODD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      abort      <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      valid <= 1'b0;
      abort <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= !start;
          if (!start) begin
            shreg   <= {incoming, shreg[WIDTH-1:1]};
            par_acc <= incoming;
            cnt     <= CW'(1);
            state   <= DATA;
          end
        end
        DATA: begin
          if (start) begin
            state   <= IDLE;
            abort   <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            par_acc <= 1'b0;
            cnt     <= '0;
          end else begin
            shreg   <= {incoming, shreg[WIDTH-1:1]};
            par_acc <= par_acc ^ incoming;
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) state <= PAR;
          end
        end
        PAR: begin
          // IDLE takes bit 0 on the very next clock, so returning there gives
          // gap-free back-to-back frames without a false abort when start rises.
          state <= IDLE;
          cnt   <= '0;
          if (start) begin
            abort <= 1'b1;
            busy  <= 1'b0;
          end else begin
            busy       <= 1'b1;
            data_out   <= shreg;
            parity_err <= perr;
            valid      <= 1'b1;
            if (perr && err_count != ERR_SAT) err_count <= err_count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_parity_rx.sv
// Randomized bench for s2p_parity_rx: even and odd parity instances share one stimulus stream.
module tb_s2p_parity_rx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset, start, incoming;
  logic [W-1:0] dout0, dout1;
  logic v0, v1, pe0, pe1, ab0, ab1, bz0, bz1;
  logic [7:0] ec0, ec1;

  s2p_parity_rx #(.WIDTH(W), .ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .start(start), .incoming(incoming),
    .data_out(dout0), .valid(v0), .parity_err(pe0), .abort(ab0),
    .busy(bz0), .err_count(ec0));

  s2p_parity_rx #(.WIDTH(W), .ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .start(start), .incoming(incoming),
    .data_out(dout1), .valid(v1), .parity_err(pe1), .abort(ab1),
    .busy(bz1), .err_count(ec1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference state: last delivered word, held parity flags, error counts.
  logic [W-1:0] m_data;
  logic         m_perr [2];
  int           m_err  [2];
  int           last_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic s, input logic b);
    @(negedge clk);
    start    = s;
    incoming = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_busy, input logic exp_abort);
    check({tag, "_valid0"}, 32'(v0), 0);
    check({tag, "_valid1"}, 32'(v1), 0);
    check({tag, "_abort0"}, 32'(ab0), 32'(exp_abort));
    check({tag, "_abort1"}, 32'(ab1), 32'(exp_abort));
    check({tag, "_busy0"}, 32'(bz0), 32'(exp_busy));
    check({tag, "_busy1"}, 32'(bz1), 32'(exp_busy));
    check({tag, "_data0"}, 32'(dout0), 32'(m_data));
    check({tag, "_data1"}, 32'(dout1), 32'(m_data));
    check({tag, "_perr0"}, 32'(pe0), 32'(m_perr[0]));
    check({tag, "_perr1"}, 32'(pe1), 32'(m_perr[1]));
    check({tag, "_ecnt0"}, 32'(ec0), 32'(m_err[0]));
    check({tag, "_ecnt1"}, 32'(ec1), 32'(m_err[1]));
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_perr[0] = 1'b0;
    m_perr[1] = 1'b0;
    m_err[0] = 0;
    m_err[1] = 0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic p);
    int ones;
    for (int i = 0; i < W; i++) begin
      tick(1'b0, w[i]);
      check_quiet("bit", 1'b1, 1'b0);
    end
    tick(1'b0, p);
    ones = $countones(w);
    m_data = w;
    // Even instance expects the bit to make the total count of ones even, odd instance odd.
    m_perr[0] = ((ones + int'(p)) % 2) != 0;
    m_perr[1] = ((ones + int'(p)) % 2) != 1;
    for (int k = 0; k < 2; k++)
      if (m_perr[k] && m_err[k] < 255) m_err[k]++;
    check("frame_valid0", 32'(v0), 1);
    check("frame_valid1", 32'(v1), 1);
    check("frame_abort0", 32'(ab0), 0);
    check("frame_abort1", 32'(ab1), 0);
    check("frame_busy0", 32'(bz0), 1);
    check("frame_data0", 32'(dout0), 32'(m_data));
    check("frame_data1", 32'(dout1), 32'(m_data));
    check("frame_perr0", 32'(pe0), 32'(m_perr[0]));
    check("frame_perr1", 32'(pe1), 32'(m_perr[1]));
    check("frame_ecnt0", 32'(ec0), 32'(m_err[0]));
    check("frame_ecnt1", 32'(ec1), 32'(m_err[1]));
    last_valid = cyc;
  endtask

  // nbits == W drops the frame on the parity cycle.
  task automatic abort_frame(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      check_quiet("abit", 1'b1, 1'b0);
    end
    tick(1'b1, 1'($urandom_range(0, 1)));
    check_quiet("abort", 1'b0, 1'b1);
  endtask

  task automatic gap();
    tick(1'b1, 1'($urandom_range(0, 1)));
    check_quiet("gap", 1'b0, 1'b0);
  endtask

  initial begin
    int t0;
    logic [W-1:0] w;
    reset    = 1'b0;
    start    = 1'b1;
    incoming = 1'b0;
    model_reset();
    last_valid = 0;
    #1;
    check_quiet("reset", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    gap();

    // 0xA5 with parity 0, then 1: even and odd instances disagree each time.
    send_frame(8'hA5, 1'b0);
    gap();
    send_frame(8'hA5, 1'b1);
    gap();

    // Back-to-back with start held low.
    send_frame(8'h3C, 1'b0);
    t0 = last_valid;
    send_frame(8'hFF, 1'b0);
    check("b2b_spacing", 32'(last_valid - t0), 32'(W + 1));
    gap();
    gap();

    // Drop after 4 data bits, and on the parity bit, then a clean frame.
    abort_frame(4);
    gap();
    send_frame(8'h01, 1'b1);
    abort_frame(W);
    send_frame(8'h80, 1'b0);
    gap();

    // Reset after 6 bits: outputs clear asynchronously, nothing strobes.
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      check_quiet("prerst", 1'b1, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    #1;
    model_reset();
    check_quiet("midrst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("postrst", 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0);

    // Random mix of frames, gaps and aborts.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) abort_frame(int'($urandom_range(1, W)));
      else send_frame(W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) gap();
    end

    // Bad parity for the even instance every time: its counter must saturate.
    for (int n = 0; n < 260; n++) begin
      w = W'($urandom);
      send_frame(w, ~(^w));
      check("sat_perr0", 32'(pe0), 1);
    end
    check("sat_count0", 32'(ec0), 255);
    gap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
